// File: rtl/fetch_align.sv
// fetch_align: instruction fetch stage that drives the instruction memory address,
// decodes 1-3 word instruction length and presents one aligned bundle per cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fetch_en          allow fetch to advance
//   redirect_valid    single-cycle branch/jump redirect, target in redirect_pc
//   mem_addr          byte address to the memory (combinational)
//   mem_inst[_1|_2]   words at the previously driven address, +2, +4
//   out_valid/ready   bundle handshake towards decode
//   out_pc, out_w0..2 bundle address and words (unused words are zero)
//   out_len           bundle length in words
//   fetch_count       completed handshakes, wrapping
module fetch_align #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_inst,
    input  logic [15:0] mem_inst_1,
    input  logic [15:0] mem_inst_2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pc,
    output logic [15:0] out_w0,
    output logic [15:0] out_w1,
    output logic [15:0] out_w2,
    output logic [1:0]  out_len,
    output logic [15:0] fetch_count
);
    logic [15:0] pc_q;
    logic        mem_vld_q;
    logic [1:0]  len;
    logic [15:0] next_pc;
    logic        accept;

    always_comb begin
        len     = mem_inst[15] ? (mem_inst[14] ? 2'd3 : 2'd2) : 2'd1;
        next_pc = pc_q + {13'd0, len, 1'b0};
        accept  = mem_vld_q & fetch_en & ~redirect_valid & (~out_valid | out_ready);
        // Holding pc_q while not accepting makes the memory re-read the same words.
        mem_addr = {redirect_valid ? redirect_pc[15:1] : accept ? next_pc[15:1] : pc_q[15:1], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC & 16'hFFFE;
            mem_vld_q   <= 1'b0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_w0      <= '0;
            out_w1      <= '0;
            out_w2      <= '0;
            out_len     <= '0;
            fetch_count <= '0;
        end else begin
            pc_q      <= mem_addr;
            mem_vld_q <= 1'b1;
            if (accept) begin
                out_pc    <= pc_q;
                out_w0    <= mem_inst;
                out_w1    <= len[1] ? mem_inst_1 : 16'd0;
                out_w2    <= (len == 2'd3) ? mem_inst_2 : 16'd0;
                out_len   <= len;
                out_valid <= 1'b1;
            end else if (redirect_valid | out_ready) begin
                // Redirect flushes the held bundle; otherwise it drains on ready.
                out_valid <= 1'b0;
            end
            if (out_valid & out_ready & ~redirect_valid)
                fetch_count <= fetch_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_fetch_align.sv
// tb_fetch_align: self-checking bench for fetch_align with a registered memory model
// and a program-order reference walk of the instruction stream.
module tb_fetch_align;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] mem_addr;
    logic [15:0] mem_inst = '0;
    logic [15:0] mem_inst_1 = '0;
    logic [15:0] mem_inst_2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_pc, out_w0, out_w1, out_w2, fetch_count;
    logic [1:0]  out_len;
    logic [15:0] mem [0:32767];
    int total = 0;
    int bad = 0;

    fetch_align #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr(mem_addr), .mem_inst(mem_inst), .mem_inst_1(mem_inst_1),
        .mem_inst_2(mem_inst_2), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_w0(out_w0), .out_w1(out_w1), .out_w2(out_w2),
        .out_len(out_len), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Synchronous memory: three consecutive words at the address seen at the edge.
    always @(posedge clk) begin
        mem_inst   <= mem[mem_addr[15:1]];
        mem_inst_1 <= mem[mem_addr[15:1] + 15'd1];
        mem_inst_2 <= mem[mem_addr[15:1] + 15'd2];
    end

    function automatic logic [1:0] ilen(input logic [15:0] w);
        return (w >= 16'hC000) ? 2'd3 : (w >= 16'h8000) ? 2'd2 : 2'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fetch_en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_mixed();
        mem[0] = 16'h8001; mem[1] = 16'h1111; mem[2] = 16'hC002;
        mem[3] = 16'h3333; mem[4] = 16'h4444; mem[5] = 16'h0003;
        mem[6] = 16'h0100; mem[7] = 16'h0200;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        fetch_en = 1'b1;
        out_ready = 1'b1;
        mem[0] = 16'h1234; mem[1] = 16'h2000; mem[2] = 16'h3000;
        tick();
        #1;
        total++;
        if ({out_valid, out_pc, out_w0, out_w1, out_w2, out_len, fetch_count, mem_addr} !== 100'd0) begin
            bad++;
            $display("FAIL reset_state: valid=%b pc=%h w0=%h w1=%h w2=%h len=%0d cnt=%h addr=%h, want all zero",
                     out_valid, out_pc, out_w0, out_w1, out_w2, out_len, fetch_count, mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_e1: valid=%b want 0", out_valid);
        end
        tick();
        total++;
        if ({out_valid, out_pc, out_w0, out_w1, out_w2, out_len} !== {1'b1, 16'h0, 16'h1234, 16'h0, 16'h0, 2'd1}) begin
            bad++;
            $display("FAIL reset_first_bundle: valid=%b pc=%h w0=%h w1=%h w2=%h len=%0d want 1/0000/1234/0000/0000/1",
                     out_valid, out_pc, out_w0, out_w1, out_w2, out_len);
        end
        tick();
        total++;
        if ({out_valid, out_pc, out_w0, out_len, fetch_count} !== {1'b1, 16'h2, 16'h2000, 2'd1, 16'd1}) begin
            bad++;
            $display("FAIL reset_second_bundle: valid=%b pc=%h w0=%h len=%0d cnt=%0d want 1/0002/2000/1/1",
                     out_valid, out_pc, out_w0, out_len, fetch_count);
        end
    endtask

    task automatic test_mixed();
        logic [15:0] ep [3];
        logic [15:0] e0 [3];
        logic [15:0] e1 [3];
        logic [15:0] e2 [3];
        logic [1:0]  el [3];
        ep = '{16'd0, 16'd4, 16'd10};
        e0 = '{16'h8001, 16'hC002, 16'h0003};
        e1 = '{16'h1111, 16'h3333, 16'h0000};
        e2 = '{16'h0000, 16'h4444, 16'h0000};
        el = '{2'd2, 2'd3, 2'd1};
        load_mixed();
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({out_valid, out_pc, out_w0, out_w1, out_w2, out_len} !== {1'b1, ep[k], e0[k], e1[k], e2[k], el[k]}) begin
                bad++;
                $display("FAIL mixed_bundle%0d: valid=%b pc=%h w=%h/%h/%h len=%0d want pc=%h w=%h/%h/%h len=%0d",
                         k, out_valid, out_pc, out_w0, out_w1, out_w2, out_len, ep[k], e0[k], e1[k], e2[k], el[k]);
            end
        end
        tick();
        total++;
        if (fetch_count !== 16'd3) begin
            bad++;
            $display("FAIL mixed_count: got %0d want 3", fetch_count);
        end
    endtask

    task automatic test_stall();
        load_mixed();
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if ({out_valid, out_pc, out_w0, out_w1, out_w2, out_len, mem_addr, fetch_count} !==
                {1'b1, 16'd4, 16'hC002, 16'h3333, 16'h4444, 2'd3, 16'd10, 16'd1}) begin
                bad++;
                $display("FAIL stall_hold%0d: valid=%b pc=%h w=%h/%h/%h len=%0d addr=%h cnt=%0d want 1/0004/c002/3333/4444/3/000a/1",
                         k, out_valid, out_pc, out_w0, out_w1, out_w2, out_len, mem_addr, fetch_count);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        total++;
        if ({out_valid, out_pc, out_w0, out_len, fetch_count} !== {1'b1, 16'd10, 16'h0003, 2'd1, 16'd2}) begin
            bad++;
            $display("FAIL stall_release: valid=%b pc=%h w0=%h len=%0d cnt=%0d want 1/000a/0003/1/2",
                     out_valid, out_pc, out_w0, out_len, fetch_count);
        end
        tick();
        total++;
        if ({out_pc, fetch_count} !== {16'd12, 16'd3}) begin
            bad++;
            $display("FAIL stall_next: pc=%h cnt=%0d want 000c/3", out_pc, fetch_count);
        end
    endtask

    task automatic test_redirect();
        load_mixed();
        mem[16'h20] = 16'h0777;
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0041;
        out_ready = 1'b1;
        #1;
        total++;
        if ({out_valid, mem_addr} !== {1'b1, 16'h0040}) begin
            bad++;
            $display("FAIL redirect_addr: valid=%b addr=%h want 1/0040", out_valid, mem_addr);
        end
        tick();
        redirect_valid = 1'b0;
        total++;
        if ({out_valid, fetch_count} !== {1'b0, 16'd0}) begin
            bad++;
            $display("FAIL redirect_flush: valid=%b cnt=%0d want 0/0", out_valid, fetch_count);
        end
        tick();
        total++;
        if ({out_valid, out_pc, out_w0, out_len} !== {1'b1, 16'h0040, 16'h0777, 2'd1}) begin
            bad++;
            $display("FAIL redirect_target: valid=%b pc=%h w0=%h len=%0d want 1/0040/0777/1",
                     out_valid, out_pc, out_w0, out_len);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] ep [4];
        logic [15:0] e0 [3];
        logic [15:0] e1 [3];
        logic [15:0] e2 [3];
        bit          hit;
        ep = '{16'hFFFA, 16'hFFFC, 16'h0000, 16'h0006};
        e0 = '{16'h0111, 16'h8222, 16'hC333};
        e1 = '{16'h0000, 16'h5555, 16'h1010};
        e2 = '{16'h0000, 16'h0000, 16'h2020};
        mem[15'h7FFD] = 16'h0111; mem[15'h7FFE] = 16'h8222; mem[15'h7FFF] = 16'h5555;
        mem[0] = 16'hC333; mem[1] = 16'h1010; mem[2] = 16'h2020;
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFA;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({out_valid, out_pc, out_w0, out_w1, out_w2} !== {1'b1, ep[k], e0[k], e1[k], e2[k]}) begin
                bad++;
                $display("FAIL wrap_bundle%0d: valid=%b pc=%h w=%h/%h/%h want pc=%h w=%h/%h/%h",
                         k, out_valid, out_pc, out_w0, out_w1, out_w2, ep[k], e0[k], e1[k], e2[k]);
            end
        end
        tick();
        total++;
        if (out_pc !== ep[3]) begin
            bad++;
            $display("FAIL wrap_after: pc=%h want %h", out_pc, ep[3]);
        end
        hit = 1'b0;
        for (int k = 0; k < 70000 && !hit; k++) begin
            if (fetch_count === 16'hFFFF) hit = 1'b1;
            else tick();
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL count_reach: cnt=%h never reached ffff", fetch_count);
        end
        tick();
        total++;
        if (fetch_count !== 16'h0000) begin
            bad++;
            $display("FAIL count_wrap: cnt=%h want 0000", fetch_count);
        end
    endtask

    task automatic test_async_reset();
        load_mixed();
        do_reset();
        fetch_en = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, fetch_count, out_pc} !== {1'b0, 16'd0, 16'd0}) begin
            bad++;
            $display("FAIL async_reset: valid=%b cnt=%0d pc=%h want 0/0/0000", out_valid, fetch_count, out_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_restart_e1: valid=%b want 0", out_valid);
        end
        tick();
        total++;
        if ({out_valid, out_pc, out_w0} !== {1'b1, 16'd0, 16'h8001}) begin
            bad++;
            $display("FAIL async_restart_e2: valid=%b pc=%h w0=%h want 1/0000/8001", out_valid, out_pc, out_w0);
        end
    endtask

    // Random ready/enable/redirect; expected stream is a program-order walk of memory.
    task automatic test_random();
        logic [15:0] exp_pc, exp_cnt, w, a1, a2, rpc;
        logic [1:0]  l;
        logic [65:0] snap, exp_b;
        bit          have_snap;
        int          errs;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        do_reset();
        exp_pc = 16'h0000;
        exp_cnt = '0;
        have_snap = 1'b0;
        errs = 0;
        for (int c = 0; c < 2000; c++) begin
            total++;
            if (fetch_count !== exp_cnt) begin
                bad++;
                errs++;
                if (errs < 10) $display("FAIL rand_count c=%0d: got %0d want %0d", c, fetch_count, exp_cnt);
            end
            if (have_snap) begin
                total++;
                if (!out_valid || {out_pc, out_w0, out_w1, out_w2, out_len} !== snap) begin
                    bad++;
                    errs++;
                    if (errs < 10) $display("FAIL rand_stable c=%0d: valid=%b bundle=%h want %h", c, out_valid,
                                            {out_pc, out_w0, out_w1, out_w2, out_len}, snap);
                end
            end
            out_ready = $urandom_range(0, 3) != 0;
            fetch_en = $urandom_range(0, 3) != 0;
            redirect_valid = $urandom_range(0, 24) == 0;
            rpc = 16'($urandom);
            redirect_pc = rpc;
            #1;
            have_snap = 1'b0;
            if (redirect_valid) begin
                exp_pc = rpc & 16'hFFFE;
                total++;
                if (mem_addr !== exp_pc) begin
                    bad++;
                    errs++;
                    if (errs < 10) $display("FAIL rand_redirect_addr c=%0d: got %h want %h", c, mem_addr, exp_pc);
                end
            end else if (out_valid && out_ready) begin
                w = mem[exp_pc[15:1]];
                l = ilen(w);
                a1 = exp_pc + 16'd2;
                a2 = exp_pc + 16'd4;
                exp_b = {exp_pc, w, (l >= 2) ? mem[a1[15:1]] : 16'd0, (l == 3) ? mem[a2[15:1]] : 16'd0, l};
                total++;
                if ({out_pc, out_w0, out_w1, out_w2, out_len} !== exp_b) begin
                    bad++;
                    errs++;
                    if (errs < 10) $display("FAIL rand_bundle c=%0d: got %h want %h", c,
                                            {out_pc, out_w0, out_w1, out_w2, out_len}, exp_b);
                end
                exp_cnt = exp_cnt + 16'd1;
                exp_pc = exp_pc + 16'(2 * l);
            end else if (out_valid) begin
                snap = {out_pc, out_w0, out_w1, out_w2, out_len};
                have_snap = 1'b1;
            end
            tick();
        end
        redirect_valid = 1'b0;
        total++;
        if (exp_cnt < 16'd200) begin
            bad++;
            $display("FAIL rand_progress: handshakes=%0d want >=200", exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_mixed();
        test_stall();
        test_redirect();
        test_async_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
